phy_tx_serializer: RTL and testbench
====================================

Name: phy_tx_serializer

Overview:
- Transmit-side PHY serializer. Forms the counterpart of the two-lane receive path.
- Accepts 32-bit words through a valid/ready handshake and byte-stripes each word across two serial lanes, serial_data_0 and serial_data_1, MSB first.
- After reset it emits COM symbols so the receiver can align, then sends data bytes or IDLE fill.
- Runs entirely on the bit clock clk_32f. Word-slot timing is derived from an internal counter.

Parameters:
- SYNC_SLOTS, 4, number of 16-bit slots of COM sent after reset before data is allowed (>=1).
- COM_SYM, 8'hBC, alignment symbol.
- IDL_SYM, 8'h7C, fill symbol sent in slots with no data.

Ports:
- clk_32f  input  1  bit clock; all flops on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- data_in  input  32  word to transmit.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  block accepts data_in on this edge when valid_in=1.
- serial_data_0  output  1  lane 0 serial bit.
- serial_data_1  output  1  lane 1 serial bit.
- sync_done  output  1  high once the SYNC phase has completed.

Behaviour:
- Reset (reset=0, asynchronous):
  - bit_cnt=0; state=SYNC; sync_cnt=0; hold register empty.
  - Both lane shift registers = {COM_SYM,COM_SYM}.
  - serial_data_0=serial_data_1=1 (MSB of 0xBC); sync_done=0; ready_out=1.
- Slot timing:
  - bit_cnt is a 4-bit free-running counter, 0..15, wrapping.
  - A slot is 16 cycles. The slot boundary is the edge at which bit_cnt==15.
- Serial outputs:
  - serial_data_N = shift_N[15], driven straight from flops.
  - On non-boundary edges, shift_N <= shift_N<<1.
  - On a boundary edge, shift_N is reloaded; the first bit of the new slot appears in the cycle where bit_cnt==0.
- Byte striping for a data slot with word W:
  - Lane 0 = {W[31:24], W[15:8]}.
  - Lane 1 = {W[23:16], W[7:0]}.
  - Each lane sends its upper byte first, MSB first within each byte.
- Hold register: one 32-bit entry plus a full flag.
  - ready_out = ~hold_full | (bit_cnt==15 & state==ACTIVE).
  - Handshake completes on an edge with valid_in=1 and ready_out=1; the word is written into hold.
- State machine:
  - SYNC: every boundary loads {COM,COM} on both lanes and sync_cnt increments. At the boundary where sync_cnt==SYNC_SLOTS-1, go to ACTIVE.
    - The post-reset slot counts as slot 0, so exactly SYNC_SLOTS COM slots are sent (16*SYNC_SLOTS cycles).
    - Words may be accepted into hold during SYNC, but are not transmitted until the first ACTIVE slot.
  - ACTIVE, at a boundary:
    - If hold_full, load its word into the shifts and clear hold_full. If a new handshake happens on the same edge, hold is refilled and stays full.
    - Otherwise load {IDL_SYM,IDL_SYM} on both lanes.
  - ACTIVE has no exit except reset.
  - sync_done is registered: it is 1 from the first ACTIVE cycle onward.
- Latency: a word accepted while hold is empty starts on the lanes in the cycle after the next boundary, at most 16 cycles after acceptance.
- Throughput: one word per slot, sustained, with no IDLE bubbles when valid_in is held high.
- Data words are never split or dropped. A word is transmitted whole in one slot, in acceptance order.
- Backpressure: while hold_full and not at a boundary, ready_out=0. data_in is ignored, and the source must hold it.
- Reset mid-slot: takes effect immediately. Any partial word and any held word are discarded, and the SYNC sequence restarts.

Test Plan:
- Reset release, valid_in=0:
  - Both lanes repeat 1011_1100 for 64 cycles, and sync_done=0 throughout.
  - Then both lanes carry 0111_1100, and sync_done=1 starting at cycle 64.
- After sync, accept 0xDEADBEEF: in the next slot, lane 0 = 11011110_10111110 (DE,BE) and lane 1 = 10101101_11101111 (AD,EF). The slot after that is IDLE.
- Hold valid_in=1 and present 0x01234567 then 0x89ABCDEF:
  - ready_out pulses only at bit_cnt==15.
  - Lane 0 carries 01,45 then 89,CD; lane 1 carries 23,67 then AB,EF.
  - There is no IDLE slot between the two words.
- Accept 0xCAFEF00D during SYNC (cycle 10): the word does not appear until cycle 64, and ready_out stays 0 from cycle 11 to 63.
- Assert reset at bit_cnt==7 of a data slot: outputs go to 1 immediately; after release there are 4 COM slots, and the old word never appears.
- With SYNC_SLOTS=1, the first data slot starts 16 cycles after reset release.

Source files
------------

// File: rtl/phy_tx_serializer.sv
`default_nettype none
// ============================================================================
// phy_tx_serializer: two-lane byte-striped TX serializer, COM sync then data/IDLE.
// Revision: 1.0
// ============================================================================
module phy_tx_serializer #(
  parameter int         SYNC_SLOTS = 4,
  parameter logic [7:0] COM_SYM    = 8'hBC,
  parameter logic [7:0] IDL_SYM    = 8'h7C
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        serial_data_0,
  output logic        serial_data_1,
  output logic        sync_done
);

  localparam int                SYNC_W    = (SYNC_SLOTS > 1) ? $clog2(SYNC_SLOTS) : 1;
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_SLOTS - 1);
  localparam logic [3:0]        SLOT_LAST = 4'd15;
  localparam logic [15:0]       COM_PAIR  = {COM_SYM, COM_SYM};
  localparam logic [15:0]       IDL_PAIR  = {IDL_SYM, IDL_SYM};

  typedef enum logic [0:0] {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t              state;
  logic [3:0]          bit_cnt;
  logic [SYNC_W-1:0]   sync_cnt;
  logic [31:0]         hold_data;
  logic                hold_full;
  logic [15:0]         shift_0;
  logic [15:0]         shift_1;

  logic                boundary;
  logic                accept;
  logic                enter_active;
  logic                send_slot;
  logic                load_word;

  assign boundary     = (bit_cnt == SLOT_LAST);
  assign ready_out    = ~hold_full | (boundary & (state == ST_ACTIVE));
  assign accept       = valid_in & ready_out;
  assign enter_active = (state == ST_SYNC) & boundary & (sync_cnt == SYNC_LAST);
  // The last SYNC boundary already opens the first ACTIVE slot, so it may carry data.
  assign send_slot    = boundary & ((state == ST_ACTIVE) | enter_active);
  assign load_word    = send_slot & hold_full;

  assign serial_data_0 = shift_0[15];
  assign serial_data_1 = shift_1[15];

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt <= 4'd0;
    end else begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= ST_SYNC;
      sync_cnt  <= '0;
      sync_done <= 1'b0;
    end else begin
      case (state)
        ST_SYNC: begin
          if (boundary) begin
            sync_cnt <= sync_cnt + 1'b1;
            if (enter_active) begin
              state     <= ST_ACTIVE;
              sync_done <= 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          sync_done <= 1'b1;
        end
        default: begin
          state <= ST_SYNC;
        end
      endcase
    end
  end

  // A new word may land in the same edge the previous one leaves, keeping hold full.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      hold_data <= 32'd0;
      hold_full <= 1'b0;
    end else begin
      if (accept) begin
        hold_data <= data_in;
        hold_full <= 1'b1;
      end else if (load_word) begin
        hold_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      shift_0 <= COM_PAIR;
      shift_1 <= COM_PAIR;
    end else if (boundary) begin
      if (!send_slot) begin
        shift_0 <= COM_PAIR;
        shift_1 <= COM_PAIR;
      end else if (hold_full) begin
        shift_0 <= {hold_data[31:24], hold_data[15:8]};
        shift_1 <= {hold_data[23:16], hold_data[7:0]};
      end else begin
        shift_0 <= IDL_PAIR;
        shift_1 <= IDL_PAIR;
      end
    end else begin
      shift_0 <= {shift_0[14:0], 1'b0};
      shift_1 <= {shift_1[14:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_serializer.sv
`default_nettype none
// ============================================================================
// tb_phy_tx_serializer: directed, table-driven check of the two-lane TX serializer.
// ============================================================================
module tb_phy_tx_serializer;

  logic        clk_32f;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic        ser0;
  logic        ser1;
  logic        sync_done;

  logic [31:0] data1;
  logic        valid1;
  logic        ready1;
  logic        ser10;
  logic        ser11;
  logic        sync_done1;

  int total;
  int bad;
  int cyc;

  typedef struct {
    logic [31:0] word;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  vec_t vecs[8];

  localparam logic [15:0] COM = 16'hBCBC;
  localparam logic [15:0] IDL = 16'h7C7C;

  phy_tx_serializer #(.SYNC_SLOTS(4)) dut (
    .clk_32f      (clk_32f),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .serial_data_0(ser0),
    .serial_data_1(ser1),
    .sync_done    (sync_done)
  );

  phy_tx_serializer #(.SYNC_SLOTS(1)) dut1 (
    .clk_32f      (clk_32f),
    .reset        (reset),
    .data_in      (data1),
    .valid_in     (valid1),
    .ready_out    (ready1),
    .serial_data_0(ser10),
    .serial_data_1(ser11),
    .sync_done    (sync_done1)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // dut1 only needs its word offered at cycle 0, so valid1 drops after every edge
  task automatic tick();
    @(posedge clk_32f);
    #1;
    cyc++;
    valid1 = 1'b0;
  endtask

  task automatic goto_off(input int k);
    while ((cyc % 16) != k) tick();
  endtask

  task automatic release_reset();
    @(posedge clk_32f);
    #1;
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic get_slot(output logic [15:0] a0, output logic [15:0] a1,
                          output logic [15:0] b0, output logic [15:0] b1,
                          output logic sd_or, output logic sd_and, output logic sd1_first);
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    sd_or = 1'b0; sd_and = 1'b1; sd1_first = sync_done1;
    for (int i = 0; i < 16; i++) begin
      a0 = {a0[14:0], ser0};
      a1 = {a1[14:0], ser1};
      b0 = {b0[14:0], ser10};
      b1 = {b1[14:0], ser11};
      sd_or  = sd_or | sync_done;
      sd_and = sd_and & sync_done;
      tick();
    end
  endtask

  logic [15:0] l0, l1, m0, m1;
  logic        sor, sand, s1f;
  int          hi_cnt;
  int          lane_bad;
  logic [15:0] com_v;

  initial begin
    vecs[0] = '{32'hDEADBEEF, 16'hDEBE, 16'hADEF};
    vecs[1] = '{32'h01234567, 16'h0145, 16'h2367};
    vecs[2] = '{32'h89ABCDEF, 16'h89CD, 16'hABEF};
    vecs[3] = '{32'hCAFEF00D, 16'hCAF0, 16'hFE0D};
    vecs[4] = '{32'h00000000, 16'h0000, 16'h0000};
    vecs[5] = '{32'hFFFFFFFF, 16'hFFFF, 16'hFFFF};
    vecs[6] = '{32'hA5A55A5A, 16'hA55A, 16'hA55A};
    vecs[7] = '{32'h12345678, 16'h1256, 16'h3478};

    total = 0; bad = 0; cyc = 0;
    reset = 1'b0; valid_in = 1'b0; data_in = '0;
    valid1 = 1'b0; data1 = 32'hDEADBEEF;
    com_v = COM;

    repeat (3) @(posedge clk_32f);
    #1;
    check("rst_lanes", {30'd0, ser0, ser1}, 32'd3);
    check("rst_sync_done", {31'd0, sync_done}, 32'd0);
    check("rst_ready", {31'd0, ready_out}, 32'd1);

    // ---- Run 1: plain sync, dut1 (SYNC_SLOTS=1) gets a word at cycle 0
    @(posedge clk_32f);
    #1;
    valid1 = 1'b1;
    reset  = 1'b1;
    cyc    = 0;
    check("s1_ready_c0", {31'd0, ready1}, 32'd1);
    for (int s = 0; s < 4; s++) begin
      get_slot(l0, l1, m0, m1, sor, sand, s1f);
      check($sformatf("sync%0d_lanes", s), {l0, l1}, {COM, COM});
      check($sformatf("sync%0d_done_low", s), {31'd0, sor}, 32'd0);
      if (s == 0) begin
        check("s1_slot0_lanes", {m0, m1}, {COM, COM});
        check("s1_slot0_done", {31'd0, s1f}, 32'd0);
      end
      if (s == 1) begin
        check("s1_slot1_lane0", {16'd0, m0}, 32'h0000DEBE);
        check("s1_slot1_lane1", {16'd0, m1}, 32'h0000ADEF);
        check("s1_slot1_done", {31'd0, s1f}, 32'd1);
      end
    end
    get_slot(l0, l1, m0, m1, sor, sand, s1f);
    check("first_active_idle", {l0, l1}, {IDL, IDL});
    check("first_active_done", {31'd0, sand}, 32'd1);

    // ---- Table: single words, each followed by an IDLE slot
    for (int i = 0; i < 8; i++) begin
      goto_off(3);
      valid_in = 1'b1;
      data_in  = vecs[i].word;
      check($sformatf("vec%0d_ready", i), {31'd0, ready_out}, 32'd1);
      tick();
      valid_in = 1'b0;
      goto_off(0);
      get_slot(l0, l1, m0, m1, sor, sand, s1f);
      check($sformatf("vec%0d_lane0", i), {16'd0, l0}, {16'd0, vecs[i].exp0});
      check($sformatf("vec%0d_lane1", i), {16'd0, l1}, {16'd0, vecs[i].exp1});
      get_slot(l0, l1, m0, m1, sor, sand, s1f);
      check($sformatf("vec%0d_then_idle", i), {l0, l1}, {IDL, IDL});
    end

    // ---- Back-to-back words with valid held high
    goto_off(3);
    valid_in = 1'b1;
    data_in  = 32'h01234567;
    check("b2b_accept_a", {31'd0, ready_out}, 32'd1);
    tick();
    data_in = 32'h89ABCDEF;
    hi_cnt  = 0;
    while ((cyc % 16) != 15) begin
      if (ready_out) hi_cnt++;
      tick();
    end
    check("b2b_ready_low_full", hi_cnt, 32'd0);
    check("b2b_ready_boundary", {31'd0, ready_out}, 32'd1);
    tick();
    valid_in = 1'b0;
    get_slot(l0, l1, m0, m1, sor, sand, s1f);
    check("b2b_a_lanes", {l0, l1}, 32'h01452367);
    get_slot(l0, l1, m0, m1, sor, sand, s1f);
    check("b2b_b_lanes", {l0, l1}, 32'h89CDABEF);
    get_slot(l0, l1, m0, m1, sor, sand, s1f);
    check("b2b_then_idle", {l0, l1}, {IDL, IDL});

    // ---- Run 2: word accepted during SYNC at cycle 10
    reset = 1'b0;
    tick();
    release_reset();
    goto_off(10);
    valid_in = 1'b1;
    data_in  = 32'hCAFEF00D;
    check("sync_accept_ready", {31'd0, ready_out}, 32'd1);
    tick();
    valid_in = 1'b0;
    hi_cnt   = 0;
    lane_bad = 0;
    while (cyc < 64) begin
      if (ready_out) hi_cnt++;
      if (ser0 !== com_v[15 - (cyc % 16)]) lane_bad++;
      if (ser1 !== com_v[15 - (cyc % 16)]) lane_bad++;
      tick();
    end
    check("sync_hold_ready_low", hi_cnt, 32'd0);
    check("sync_hold_lanes_com", lane_bad, 32'd0);
    get_slot(l0, l1, m0, m1, sor, sand, s1f);
    check("sync_word_lanes", {l0, l1}, 32'hCAF0FE0D);
    check("sync_word_done", {31'd0, sand}, 32'd1);

    // ---- Reset in the middle of a data slot with another word held
    goto_off(3);
    valid_in = 1'b1;
    data_in  = 32'h12345678;
    tick();
    valid_in = 1'b0;
    goto_off(0);
    goto_off(4);
    valid_in = 1'b1;
    data_in  = 32'h89ABCDEF;
    tick();
    valid_in = 1'b0;
    goto_off(7);
    check("pre_rst_lanes", {30'd0, ser0, ser1}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_lanes", {30'd0, ser0, ser1}, 32'd3);
    check("mid_rst_done", {31'd0, sync_done}, 32'd0);
    check("mid_rst_ready", {31'd0, ready_out}, 32'd1);
    tick();
    tick();
    release_reset();
    for (int s = 0; s < 4; s++) begin
      get_slot(l0, l1, m0, m1, sor, sand, s1f);
      check($sformatf("resync%0d_lanes", s), {l0, l1}, {COM, COM});
      check($sformatf("resync%0d_done_low", s), {31'd0, sor}, 32'd0);
    end
    for (int s = 0; s < 2; s++) begin
      get_slot(l0, l1, m0, m1, sor, sand, s1f);
      check($sformatf("resync_idle%0d", s), {l0, l1}, {IDL, IDL});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
